// File: rtl/emsensor_alarm_responder.sv
// Alarm responder for the EM/timing sensor: synchronises the raw alarm, confirms an attack
// inside an observation window, then drives key zeroization, core halt, strike counting and lockout.
module emsensor_alarm_responder #(
    parameter int WINDOW      = 16,
    parameter int THRESH      = 2,
    parameter int HOLD_CYCLES = 256,
    parameter int MAX_STRIKES = 3
) (
    input  logic       vclk,
    input  logic       vrst,
    input  logic       alarm_in,
    input  logic       enable,
    input  logic       irq_clr,
    input  logic       zeroize_ack,
    output logic       zeroize_req,
    output logic       halt_o,
    output logic       irq_o,
    output logic       locked_o,
    output logic [3:0] strike_cnt,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WINDOW  = 3'd1,
        ST_RESPOND = 3'd2,
        ST_HOLD    = 3'd3,
        ST_LOCKED  = 3'd4
    } state_t;

    localparam int WIN_W  = $clog2(WINDOW + 1);
    localparam int HIT_W  = $clog2(THRESH + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [HIT_W:0]    THRESH_V  = (HIT_W + 1)'(THRESH);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [3:0]        MAX_V     = 4'(MAX_STRIKES);

    logic              sync_q;
    logic              alarm_s;
    state_t            state;
    logic [WIN_W-1:0]  win_cnt;
    logic [HIT_W-1:0]  hit_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HIT_W:0]    hit_next;

    // One bit wider than hit_cnt so the increment can never wrap before the compare.
    assign hit_next = {1'b0, hit_cnt} + {{HIT_W{1'b0}}, alarm_s};

    assign zeroize_req = (state == ST_RESPOND);
    assign halt_o      = (state == ST_RESPOND) || (state == ST_HOLD) || (state == ST_LOCKED);
    assign locked_o    = (state == ST_LOCKED);
    assign state_o     = state;

    // Two-flop synchroniser for the asynchronous, possibly glitching sensor alarm.
    always_ff @(posedge vclk) begin
        if (vrst) begin
            sync_q  <= 1'b0;
            alarm_s <= 1'b0;
        end else begin
            sync_q  <= alarm_in;
            alarm_s <= sync_q;
        end
    end

    // Response FSM with its window/hold counters, strike counter and sticky interrupt.
    always_ff @(posedge vclk) begin
        if (vrst) begin
            state      <= ST_IDLE;
            win_cnt    <= '0;
            hit_cnt    <= '0;
            hold_cnt   <= '0;
            strike_cnt <= 4'd0;
            irq_o      <= 1'b0;
        end else begin
            // A set later in this block overrides the clear, so set wins on collision.
            if (irq_clr) begin
                irq_o <= 1'b0;
            end else begin
                irq_o <= irq_o;
            end

            case (state)
                ST_IDLE: begin
                    if (alarm_s && enable) begin
                        if (THRESH == 1) begin
                            state <= ST_RESPOND;
                        end else begin
                            state   <= ST_WINDOW;
                            hit_cnt <= HIT_W'(1);
                            win_cnt <= '0;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_WINDOW: begin
                    if (!enable) begin
                        state   <= ST_IDLE;
                        win_cnt <= '0;
                        hit_cnt <= '0;
                    end else if (hit_next >= THRESH_V) begin
                        state   <= ST_RESPOND;
                        win_cnt <= '0;
                        hit_cnt <= '0;
                    end else if (win_cnt == WIN_LAST) begin
                        state   <= ST_IDLE;
                        win_cnt <= '0;
                        hit_cnt <= '0;
                    end else begin
                        win_cnt <= win_cnt + WIN_W'(1);
                        hit_cnt <= hit_next[HIT_W-1:0];
                    end
                end

                ST_RESPOND: begin
                    if (zeroize_ack) begin
                        state    <= ST_HOLD;
                        hold_cnt <= '0;
                        irq_o    <= 1'b1;
                        if (strike_cnt != 4'd15) begin
                            strike_cnt <= strike_cnt + 4'd1;
                        end else begin
                            strike_cnt <= strike_cnt;
                        end
                    end else begin
                        state <= ST_RESPOND;
                    end
                end

                ST_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        if (strike_cnt >= MAX_V) begin
                            state <= ST_LOCKED;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end

                ST_LOCKED: begin
                    state <= ST_LOCKED;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_emsensor_alarm_responder.sv
// Scoreboard bench for emsensor_alarm_responder: directed scenarios then randomized traffic,
// every cycle compared against a behavioural model of the responder.
module tb_emsensor_alarm_responder;

    localparam int WINDOW      = 16;
    localparam int THRESH      = 2;
    localparam int HOLD_CYCLES = 256;
    localparam int MAX_STRIKES = 3;

    logic       vclk = 1'b0;
    logic       vrst = 1'b1;
    logic       alarm_in = 1'b0;
    logic       enable = 1'b0;
    logic       irq_clr = 1'b0;
    logic       zeroize_ack = 1'b0;
    logic       zeroize_req;
    logic       halt_o;
    logic       irq_o;
    logic       locked_o;
    logic [3:0] strike_cnt;
    logic [2:0] state_o;

    emsensor_alarm_responder #(
        .WINDOW(WINDOW), .THRESH(THRESH), .HOLD_CYCLES(HOLD_CYCLES), .MAX_STRIKES(MAX_STRIKES)
    ) dut (
        .vclk(vclk), .vrst(vrst), .alarm_in(alarm_in), .enable(enable), .irq_clr(irq_clr),
        .zeroize_ack(zeroize_ack), .zeroize_req(zeroize_req), .halt_o(halt_o), .irq_o(irq_o),
        .locked_o(locked_o), .strike_cnt(strike_cnt), .state_o(state_o)
    );

    always #5 vclk = ~vclk;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;
    logic [10:0] exp_q[$];

    // Reference model: mode 0 idle, 1 observing, 2 awaiting ack, 3 holding, 4 locked.
    bit m_s1, m_s2, m_irq;
    int m_mode, m_hits, m_elapsed, m_hold, m_strikes, lock_len;

    task automatic model_step(input bit r, input bit a, input bit en, input bit clr, input bit ack);
        bit seen;
        bit set;
        if (r) begin
            m_s1 = 0; m_s2 = 0; m_irq = 0;
            m_mode = 0; m_hits = 0; m_elapsed = 0; m_hold = 0; m_strikes = 0;
            return;
        end
        seen = m_s2;
        m_s2 = m_s1;
        m_s1 = a;
        set  = 0;
        case (m_mode)
            0: if (seen && en) begin
                if (THRESH == 1) m_mode = 2;
                else begin m_mode = 1; m_hits = 1; m_elapsed = 0; end
            end
            1: if (!en) m_mode = 0;
            else begin
                m_hits += int'(seen);
                m_elapsed++;
                if (m_hits >= THRESH) m_mode = 2;
                else if (m_elapsed == WINDOW) m_mode = 0;
            end
            2: if (ack) begin
                set = 1;
                m_strikes = (m_strikes < 15) ? m_strikes + 1 : 15;
                m_hold = HOLD_CYCLES;
                m_mode = 3;
            end
            3: begin
                m_hold--;
                if (m_hold == 0) m_mode = (m_strikes >= MAX_STRIKES) ? 4 : 0;
            end
            default: ;
        endcase
        if (set) m_irq = 1;
        else if (clr) m_irq = 0;
    endtask

    function automatic logic [10:0] expected();
        return {m_mode == 2, m_mode >= 2, m_irq, m_mode == 4, 4'(m_strikes), 3'(m_mode)};
    endfunction

    task automatic drive(input bit r, input bit a, input bit en, input bit clr, input bit ack);
        @(negedge vclk);
        vrst = r; alarm_in = a; enable = en; irq_clr = clr; zeroize_ack = ack;
        model_step(r, a, en, clr, ack);
        exp_q.push_back(expected());
        started = 1'b1;
    endtask

    task automatic idle(input int n, input bit en);
        for (int i = 0; i < n; i++) drive(0, 0, en, 0, 0);
    endtask

    // Two-cycle alarm burst, wait until the model reaches the ack wait, then ack after dly cycles.
    task automatic attack(input int dly, input bit clr_on_ack, input bit drop_en);
        drive(0, 1, 1, 0, 0);
        drive(0, 1, 1, 0, 0);
        for (int i = 0; i < 40 && m_mode != 2; i++) drive(0, 0, 1, 0, 0);
        for (int i = 0; i < dly; i++) drive(0, 0, !drop_en, 0, 0);
        drive(0, 0, 1, clr_on_ack, 1);
    endtask

    // Monitor: the DUT presents a result every cycle; pop and compare just after each edge.
    initial begin
        logic [10:0] want;
        logic [10:0] got;
        forever begin
            @(posedge vclk);
            #1;
            got = {zeroize_req, halt_o, irq_o, locked_o, strike_cnt, state_o};
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                n_cmp++;
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL outputs t=%0t got req/halt/irq/lock/strike/state=%b want=%b",
                             $time, got, want);
                end
            end else if (started) begin
                n_bad++;
                $display("FAIL no_expectation t=%0t got=%b want=<none>", $time, got);
            end
        end
    end

    initial begin
        int p;
        bit r, a, en, clr, ack;
        for (int i = 0; i < 3; i++) drive(1, 0, 1, 0, 0);

        // Lone one-cycle pulse: window opens and expires without confirming.
        drive(0, 1, 1, 0, 0);
        idle(25, 1);

        // Confirmed attack, ack after 5 cycles with irq_clr colliding, full hold, then clear.
        attack(5, 1, 0);
        idle(260, 1);
        drive(0, 0, 1, 1, 0);
        idle(3, 1);

        // Two more strikes to lock, poke the locked state, then reset out of it.
        attack(0, 0, 0);
        idle(260, 1);
        attack(2, 0, 0);
        idle(262, 1);
        for (int i = 0; i < 30; i++)
            drive(0, 1'($urandom_range(0, 1)), 1, 0, 1'($urandom_range(0, 1)));
        drive(1, 0, 1, 0, 0);
        idle(3, 1);

        // Enable gating: disabled alarm, enable dropped mid-window, enable dropped while awaiting ack.
        for (int i = 0; i < 50; i++) drive(0, 1, 0, 0, 0);
        idle(4, 1);
        drive(0, 1, 1, 0, 0);
        idle(6, 1);
        drive(0, 0, 0, 0, 0);
        idle(5, 1);
        attack(10, 0, 1);
        idle(260, 1);

        // Reset in the middle of the hold period.
        attack(1, 0, 0);
        idle(100, 1);
        drive(1, 0, 1, 0, 0);
        idle(5, 1);

        // Randomized bursty traffic with occasional resets and forced exit from lockout.
        lock_len = 0;
        for (int seg = 0; seg < 150; seg++) begin
            case ($urandom_range(0, 3))
                0: p = 3;
                1: p = 10;
                2: p = 30;
                default: p = 70;
            endcase
            for (int c = 0; c < 40; c++) begin
                lock_len = (m_mode == 4) ? lock_len + 1 : 0;
                r   = ($urandom_range(0, 999) < 2) || (lock_len > 30);
                a   = ($urandom_range(0, 99) < p);
                en  = ($urandom_range(0, 99) < 95);
                clr = ($urandom_range(0, 99) < 10);
                ack = ($urandom_range(0, 99) < 25);
                drive(r, a, en, clr, ack);
            end
        end

        @(posedge vclk);
        #2;
        started = 1'b0;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_expectations got=%0d want=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
